// File: rtl/rcv_packet_ctrl.sv
// Receive packet controller: checks the sync byte, gates payload writes into the
// downstream FIFO, counts payload bytes and latches the first error of each packet.
module rcv_packet_ctrl #(
  parameter int unsigned       DATA_W       = 8,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = 8'h80,
  parameter int unsigned       MAX_BYTES    = 64,
  parameter int unsigned       TIMEOUT_CYC  = 255,
  parameter int unsigned       CNT_W        = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_edge,
  input  logic              eop,
  input  logic              shift_enable,
  input  logic [DATA_W-1:0] rcv_data,
  input  logic              byte_received,
  input  logic              fifo_full,
  output logic              rcving,
  output logic              w_enable,
  output logic              r_error,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  byte_count,
  output logic              pkt_done
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BYTES);

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_BAD_SYNC = 3'b001;
  localparam logic [2:0] ERR_EARLY    = 3'b010;
  localparam logic [2:0] ERR_OVERFLOW = 3'b011;
  localparam logic [2:0] ERR_FULL     = 3'b100;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b101;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHECK,
    RECEIVE,
    STORE,
    SHIFT_WAIT,
    DONE,
    ERR_DISCARD,
    ERR_HOLD
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_active;
  logic             timeout;
  logic             eop_strobe;

  assign tmo_active = (state == SYNC_WAIT) || (state == RECEIVE);
  assign timeout    = (tmo_cnt == TMO_LIMIT);
  assign eop_strobe = eop && shift_enable;

  // Outputs decode straight from the state register so reset clears them at once.
  assign rcving   = (state == SYNC_WAIT) || (state == SYNC_CHECK) || (state == RECEIVE) ||
                    (state == STORE) || (state == SHIFT_WAIT) || (state == ERR_DISCARD);
  assign w_enable = (state == STORE) && !fifo_full;
  assign r_error  = (state == ERR_DISCARD) || (state == ERR_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_count <= '0;
      err_code   <= ERR_NONE;
      tmo_cnt    <= '0;
      pkt_done   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;

      // Bus-idle timer: any data-line transition restarts it; it saturates at the limit.
      if (d_edge) begin
        tmo_cnt <= '0;
      end else if (tmo_active && !timeout) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (d_edge) begin
            state      <= SYNC_WAIT;
            byte_count <= '0;
            err_code   <= ERR_NONE;
          end
        end
        SYNC_WAIT: begin
          if (timeout) begin
            state    <= ERR_HOLD;
            err_code <= ERR_TIMEOUT;
          end else if (byte_received) begin
            state <= SYNC_CHECK;
          end
        end
        SYNC_CHECK: begin
          if (rcv_data == SYNC_PATTERN) begin
            state <= RECEIVE;
          end else begin
            state    <= ERR_DISCARD;
            err_code <= ERR_BAD_SYNC;
          end
        end
        RECEIVE: begin
          if (eop_strobe) begin
            state    <= ERR_DISCARD;
            err_code <= ERR_EARLY;
          end else if (timeout) begin
            state    <= ERR_HOLD;
            err_code <= ERR_TIMEOUT;
          end else if (byte_received) begin
            if (byte_count == CNT_LIMIT) begin
              state    <= ERR_DISCARD;
              err_code <= ERR_OVERFLOW;
            end else begin
              state <= STORE;
            end
          end
        end
        STORE: begin
          if (fifo_full) begin
            state    <= ERR_DISCARD;
            err_code <= ERR_FULL;
          end else begin
            state      <= SHIFT_WAIT;
            byte_count <= byte_count + 1'b1;
          end
        end
        SHIFT_WAIT: begin
          if (shift_enable) begin
            if (eop) begin
              state    <= DONE;
              pkt_done <= 1'b1;
            end else begin
              state <= RECEIVE;
            end
          end
        end
        DONE: begin
          if (d_edge) begin
            state <= IDLE;
          end
        end
        ERR_DISCARD: begin
          if (eop_strobe) begin
            state <= ERR_HOLD;
          end
        end
        ERR_HOLD: begin
          if (d_edge) begin
            state      <= SYNC_WAIT;
            byte_count <= '0;
            err_code   <= ERR_NONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcv_packet_ctrl.sv
// Bench for rcv_packet_ctrl: directed packets plus a per-cycle scoreboard of FIFO writes.
module tb_rcv_packet_ctrl;

  localparam int DATA_W      = 8;
  localparam int MAX_BYTES   = 4;
  localparam int TIMEOUT_CYC = 10;
  localparam int CNT_W       = $clog2(MAX_BYTES + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              d_edge = 1'b0;
  logic              eop = 1'b0;
  logic              shift_enable = 1'b0;
  logic [DATA_W-1:0] rcv_data = '0;
  logic              byte_received = 1'b0;
  logic              fifo_full = 1'b0;
  logic              rcving;
  logic              w_enable;
  logic              r_error;
  logic [2:0]        err_code;
  logic [CNT_W-1:0]  byte_count;
  logic              pkt_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard: bytes the FIFO must receive, in order, and running write/packet tallies.
  logic [DATA_W-1:0] exp_q[$];
  int   wr_cnt   = 0;
  int   wr_total = 0;
  int   pkt_cnt  = 0;
  logic prev_rcving   = 1'b0;
  logic prev_pkt_done = 1'b0;

  rcv_packet_ctrl #(
    .DATA_W(DATA_W),
    .SYNC_PATTERN(8'h80),
    .MAX_BYTES(MAX_BYTES),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .d_edge(d_edge),
    .eop(eop),
    .shift_enable(shift_enable),
    .rcv_data(rcv_data),
    .byte_received(byte_received),
    .fifo_full(fifo_full),
    .rcving(rcving),
    .w_enable(w_enable),
    .r_error(r_error),
    .err_code(err_code),
    .byte_count(byte_count),
    .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs_zero",
            {24'd0, rcving, w_enable, r_error, pkt_done, err_code, 1'b0} | 32'(byte_count), 32'd0);
      wr_cnt        = 0;
      prev_rcving   = 1'b0;
      prev_pkt_done = 1'b0;
    end else begin
      if (rcving && !prev_rcving) wr_cnt = 0;
      check("byte_count_vs_writes", 32'(byte_count), wr_cnt);
      check("r_error_iff_err_code", {31'd0, r_error}, {31'd0, err_code != 3'b000});
      check("byte_count_bound", {31'd0, byte_count <= MAX_BYTES}, 32'd1);
      if (w_enable) begin
        check("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check("write_data", 32'(rcv_data), 32'(exp_q.pop_front()));
        wr_cnt++;
        wr_total++;
      end
      if (pkt_done) begin
        pkt_cnt++;
        check("pkt_done_single_cycle", {31'd0, prev_pkt_done}, 32'd0);
        check("pkt_done_clean", {30'd0, r_error, rcving}, 32'd0);
      end
      prev_rcving   = rcving;
      prev_pkt_done = pkt_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic full);
    d_edge        = 1'b1;
    byte_received = 1'b1;
    rcv_data      = b;
    fifo_full     = full;
    tick();
    d_edge        = 1'b0;
    byte_received = 1'b0;
    tick();
    fifo_full     = 1'b0;
  endtask

  task automatic shift(input logic e);
    shift_enable = 1'b1;
    eop          = e;
    tick();
    shift_enable = 1'b0;
    eop          = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int base_wr;
    int base_pkt;
    bit seen;

    // Reset state
    repeat (3) tick();
    check("reset_rcving", {31'd0, rcving}, 32'd0);
    check("reset_err_code", {29'd0, err_code}, 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_count", 32'(byte_count), 32'd0);
    check("post_reset_r_error", {31'd0, r_error}, 32'd0);

    // Clean packet: sync, A1 B2 C3, EOP
    base_wr  = wr_total;
    base_pkt = pkt_cnt;
    start_pkt();
    check("clean_rcving", {31'd0, rcving}, 32'd1);
    send_byte(8'h80, 1'b0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3);
    send_byte(8'hA1, 1'b0); shift(1'b0);
    send_byte(8'hB2, 1'b0); shift(1'b0);
    send_byte(8'hC3, 1'b0); shift(1'b1);
    check("clean_pkt_done_high", {31'd0, pkt_done}, 32'd1);
    tick();
    check("clean_pkt_done_low", {31'd0, pkt_done}, 32'd0);
    check("clean_writes", wr_total - base_wr, 32'd3);
    check("clean_byte_count", 32'(byte_count), 32'd3);
    check("clean_pkt_cnt", pkt_cnt - base_pkt, 32'd1);
    check("clean_r_error", {31'd0, r_error}, 32'd0);
    check("clean_queue_empty", exp_q.size(), 32'd0);
    d_edge = 1'b1; tick(); d_edge = 1'b0;
    check("done_to_idle_rcving", {31'd0, rcving}, 32'd0);
    check("idle_count_holds", 32'(byte_count), 32'd3);

    // Bad sync 0x81, then EOP; error held until the next d_edge
    base_wr = wr_total;
    start_pkt();
    send_byte(8'h81, 1'b0);
    check("badsync_r_error", {31'd0, r_error}, 32'd1);
    check("badsync_err_code", {29'd0, err_code}, 32'd1);
    check("badsync_discarding", {31'd0, rcving}, 32'd1);
    shift(1'b1);
    repeat (3) tick();
    check("badsync_hold_r_error", {31'd0, r_error}, 32'd1);
    check("badsync_hold_err_code", {29'd0, err_code}, 32'd1);
    check("badsync_hold_rcving", {31'd0, rcving}, 32'd0);
    check("badsync_writes", wr_total - base_wr, 32'd0);
    start_pkt();
    check("restart_err_cleared", {29'd0, err_code}, 32'd0);
    check("restart_rcving", {31'd0, rcving}, 32'd1);
    send_byte(8'h80, 1'b0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b0); shift(1'b1);
    check("restart_pkt_done", {31'd0, pkt_done}, 32'd1);
    check("restart_byte_count", 32'(byte_count), 32'd1);
    tick();
    d_edge = 1'b1; tick(); d_edge = 1'b0;

    // Overflow: sync then five bytes with a four-byte limit
    base_wr = wr_total;
    start_pkt();
    send_byte(8'h80, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i), 1'b0);
      if (i < 4) shift(1'b0);
    end
    check("ovf_writes", wr_total - base_wr, 32'd4);
    check("ovf_err_code", {29'd0, err_code}, 32'd3);
    check("ovf_byte_count", 32'(byte_count), 32'd4);
    check("ovf_r_error", {31'd0, r_error}, 32'd1);
    shift(1'b1);
    check("ovf_hold_rcving", {31'd0, rcving}, 32'd0);

    // FIFO full on the second payload byte
    base_wr = wr_total;
    start_pkt();
    send_byte(8'h80, 1'b0);
    exp_q.push_back(8'h21);
    send_byte(8'h21, 1'b0); shift(1'b0);
    send_byte(8'h22, 1'b1);
    check("full_err_code", {29'd0, err_code}, 32'd4);
    check("full_byte_count", 32'(byte_count), 32'd1);
    check("full_discarding", {31'd0, rcving}, 32'd1);
    send_byte(8'h23, 1'b0); shift(1'b0);
    shift(1'b1);
    check("full_writes", wr_total - base_wr, 32'd1);
    check("full_hold_rcving", {31'd0, rcving}, 32'd0);
    check("full_hold_err_code", {29'd0, err_code}, 32'd4);

    // Timeout in RECEIVE: bus goes quiet after the sync byte
    start_pkt();
    send_byte(8'h80, 1'b0);
    repeat (9) tick();
    check("tmo_not_yet", {31'd0, r_error}, 32'd0);
    check("tmo_still_rcving", {31'd0, rcving}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = r_error;
    end
    check("tmo_fired", {31'd0, seen}, 32'd1);
    check("tmo_err_code", {29'd0, err_code}, 32'd5);
    check("tmo_rcving", {31'd0, rcving}, 32'd0);

    // Timeout while waiting for the sync byte
    start_pkt();
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      seen = r_error;
    end
    check("sync_tmo_fired", {31'd0, seen}, 32'd1);
    check("sync_tmo_err_code", {29'd0, err_code}, 32'd5);

    // Reset in RECEIVE after two writes, then a clean one-byte packet
    start_pkt();
    send_byte(8'h80, 1'b0);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    send_byte(8'h31, 1'b0); shift(1'b0);
    send_byte(8'h32, 1'b0); shift(1'b0);
    check("prerst_byte_count", 32'(byte_count), 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {26'd0, rcving, w_enable, r_error, pkt_done, 2'b00}, 32'd0);
    check("midrst_err_code", {29'd0, err_code}, 32'd0);
    check("midrst_byte_count", 32'(byte_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    base_pkt = pkt_cnt;
    start_pkt();
    send_byte(8'h80, 1'b0);
    exp_q.push_back(8'h44);
    send_byte(8'h44, 1'b0); shift(1'b1);
    check("postrst_byte_count", 32'(byte_count), 32'd1);
    check("postrst_pkt_done", {31'd0, pkt_done}, 32'd1);
    tick();
    check("postrst_pkt_cnt", pkt_cnt - base_pkt, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
